// File: rtl/mig_if_pkg.sv
// Shared MIG user-interface definitions for the cache-line initiator:
// command encodings, line offset width and the initiator state encoding.
package mig_if_pkg;

   localparam logic [2:0] MIG_CMD_WR = 3'b000;
   localparam logic [2:0] MIG_CMD_RD = 3'b001;
   localparam int         LINE_OFS_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RWAIT = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/mig_timeout_cnt.sv
// Saturating watchdog counter for the MIG wait states; expired is raised
// once TO_CYC enabled cycles have elapsed since the last clear.
module mig_timeout_cnt #(
   parameter int TO_CYC = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TO_CYC + 1);

   logic [CNT_W-1:0] count;

   assign expired = (count == CNT_W'(TO_CYC));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mig_line_initiator.sv
// Cache-miss path initiator: turns one 128-bit line fill or writeback at a
// time into MIG UI command/write-data handshakes, with a sticky timeout flag.
module mig_line_initiator
   import mig_if_pkg::*;
#(
   parameter int ADR_W  = 28,
   parameter int DATA_W = 128,
   parameter int TO_CYC = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_wr,
   input  logic [ADR_W-5:0]      req_adr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  req_ready,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic [ADR_W-1:0]      app_addr,
   output logic [2:0]            app_cmd,
   output logic                  app_en,
   input  logic                  app_rdy,
   output logic [DATA_W-1:0]     app_wdf_data,
   output logic                  app_wdf_wren,
   output logic                  app_wdf_end,
   output logic [DATA_W/8-1:0]   app_wdf_mask,
   input  logic                  app_wdf_rdy,
   input  logic [DATA_W-1:0]     app_rd_data,
   input  logic                  app_rd_data_valid,
   input  logic                  app_rd_data_end
);

   state_t              state, state_nxt;
   logic [ADR_W-5:0]    adr_q;
   logic                wr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                cmd_done, wdf_done;
   logic                accept, cmd_hs, wdf_hs, capture, set_err;
   logic                expired, to_enable;
   logic                unused;

   // Lines are always a single beat, so the read end strobe carries nothing.
   assign unused = app_rd_data_end;

   assign app_addr     = {adr_q, LINE_OFS_W'(0)};
   assign app_wdf_data = wdata_q;
   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_mask = '0;
   assign to_enable    = (state == ISSUE) || (state == RWAIT);

   mig_timeout_cnt #(.TO_CYC(TO_CYC)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .enable  (to_enable),
      .expired (expired)
   );

   always_comb begin
      state_nxt    = state;
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      app_cmd      = MIG_CMD_WR;
      accept       = 1'b0;
      cmd_hs       = 1'b0;
      wdf_hs       = 1'b0;
      capture      = 1'b0;
      set_err      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         // Strobes are withdrawn on expiry so the MIG never sees a late handshake.
         ISSUE: begin
            app_en       = !cmd_done && !expired;
            app_cmd      = wr_q ? MIG_CMD_WR : MIG_CMD_RD;
            app_wdf_wren = wr_q && !wdf_done && !expired;
            cmd_hs       = app_en && app_rdy;
            wdf_hs       = app_wdf_wren && app_wdf_rdy;
            if ((cmd_done || cmd_hs) && (!wr_q || wdf_done || wdf_hs)) begin
               state_nxt = wr_q ? RESP : RWAIT;
            end else if (expired) begin
               set_err   = 1'b1;
               state_nxt = RESP;
            end
         end
         RWAIT: begin
            if (app_rd_data_valid) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else if (expired) begin
               set_err   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         adr_q     <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         cmd_done  <= 1'b0;
         wdf_done  <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            adr_q    <= req_adr;
            wr_q     <= req_wr;
            wdata_q  <= req_wdata;
            cmd_done <= 1'b0;
            wdf_done <= 1'b0;
         end else begin
            if (cmd_hs) cmd_done <= 1'b1;
            if (wdf_hs) wdf_done <= 1'b1;
         end
         if (capture) rsp_rdata <= app_rd_data;
         if (set_err) rsp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mig_line_initiator.sv
// Directed bench for mig_line_initiator: a scripted MIG responder drives the
// UI side while a response scoreboard checks every completion.
module tb_mig_line_initiator;

   localparam int ADR_W  = 28;
   localparam int DATA_W = 128;
   localparam int TO_CYC = 15;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } rsp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                req_valid, req_wr;
   logic [ADR_W-5:0]    req_adr;
   logic [DATA_W-1:0]   req_wdata;
   logic                req_ready, rsp_valid, rsp_err;
   logic [DATA_W-1:0]   rsp_rdata;
   logic [ADR_W-1:0]    app_addr;
   logic [2:0]          app_cmd;
   logic                app_en, app_rdy;
   logic [DATA_W-1:0]   app_wdf_data;
   logic                app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [DATA_W/8-1:0] app_wdf_mask;
   logic [DATA_W-1:0]   app_rd_data;
   logic                app_rd_data_valid, app_rd_data_end;

   int   total = 0;
   int   bad   = 0;
   rsp_t sb[$];

   always #5 clk = ~clk;

   mig_line_initiator #(.ADR_W(ADR_W), .DATA_W(DATA_W), .TO_CYC(TO_CYC)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_wr            (req_wr),
      .req_adr           (req_adr),
      .req_wdata         (req_wdata),
      .req_ready         (req_ready),
      .rsp_valid         (rsp_valid),
      .rsp_rdata         (rsp_rdata),
      .rsp_err           (rsp_err),
      .app_addr          (app_addr),
      .app_cmd           (app_cmd),
      .app_en            (app_en),
      .app_rdy           (app_rdy),
      .app_wdf_data      (app_wdf_data),
      .app_wdf_wren      (app_wdf_wren),
      .app_wdf_end       (app_wdf_end),
      .app_wdf_mask      (app_wdf_mask),
      .app_wdf_rdy       (app_wdf_rdy),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid),
      .app_rd_data_end   (app_rd_data_end)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the completion pulse and scores it against the queue.
   task automatic wait_rsp(input string tag, input int budget, output int cycles);
      rsp_t exp;
      cycles = 0;
      while (!rsp_valid && cycles < budget) begin
         tick();
         cycles++;
      end
      check({tag, "_rsp_seen"}, DATA_W'(rsp_valid), DATA_W'(1));
      if (rsp_valid) begin
         check({tag, "_sb_nonempty"}, DATA_W'(sb.size() > 0), DATA_W'(1));
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, "_rdata"}, rsp_rdata, exp.rdata);
            check({tag, "_err"}, DATA_W'(rsp_err), DATA_W'(exp.err));
         end
      end
   endtask

   task automatic send_req(input logic wr, input logic [ADR_W-5:0] adr,
                           input logic [DATA_W-1:0] wdata);
      req_valid = 1'b1;
      req_wr    = wr;
      req_adr   = adr;
      req_wdata = wdata;
   endtask

   initial begin
      logic [DATA_W-1:0] d1, d2, w1, w2, w3;
      int                cyc;
      d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
      d2 = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
      w1 = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
      w2 = 128'hDEADBEEF_CAFEF00D_01020304_05060708;
      w3 = 128'h13579BDF_2468ACE0_FFFF0000_AAAA5555;

      rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_adr = '0; req_wdata = '0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0;
      app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
      repeat (3) tick();

      check("reset_req_ready", DATA_W'(req_ready), DATA_W'(1));
      check("reset_app_en", DATA_W'(app_en), DATA_W'(0));
      check("reset_wren", DATA_W'(app_wdf_wren), DATA_W'(0));
      check("reset_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
      check("reset_rsp_err", DATA_W'(rsp_err), DATA_W'(0));
      check("reset_app_addr", DATA_W'(app_addr), DATA_W'(0));
      check("reset_app_cmd", DATA_W'(app_cmd), DATA_W'(0));
      check("reset_rsp_rdata", rsp_rdata, '0);
      rst = 1'b0;
      tick();

      // Fill with an ideal MIG, data 5 cycles after accept.
      $display("[TB] fill, ideal MIG");
      app_rdy = 1'b1;
      send_req(1'b0, 24'h000040, '0);
      sb.push_back('{rdata: d1, err: 1'b0});
      tick();
      req_valid = 1'b0;
      check("fill_app_en", DATA_W'(app_en), DATA_W'(1));
      check("fill_app_addr", DATA_W'(app_addr), DATA_W'(28'h0000400));
      check("fill_app_cmd", DATA_W'(app_cmd), DATA_W'(3'b001));
      check("fill_req_ready", DATA_W'(req_ready), DATA_W'(0));
      check("fill_no_wren", DATA_W'(app_wdf_wren), DATA_W'(0));
      check("fill_mask", DATA_W'(app_wdf_mask), DATA_W'(0));
      tick();
      check("fill_app_en_drop", DATA_W'(app_en), DATA_W'(0));
      repeat (3) tick();
      check("fill_no_early_rsp", DATA_W'(rsp_valid), DATA_W'(0));
      app_rd_data = d1; app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0; app_rd_data = '0;
      wait_rsp("fill", 20, cyc);
      check("fill_latency", DATA_W'(cyc), DATA_W'(0));
      tick();
      check("fill_pulse_once", DATA_W'(rsp_valid), DATA_W'(0));
      check("fill_ready_back", DATA_W'(req_ready), DATA_W'(1));

      // Writeback: data accepted at once, command held off 4 cycles.
      $display("[TB] writeback, data before command");
      app_rdy = 1'b0; app_wdf_rdy = 1'b1;
      send_req(1'b1, 24'h0ABCDE, w1);
      sb.push_back('{rdata: d1, err: 1'b0});
      tick();
      req_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         check("wb1_app_en", DATA_W'(app_en), DATA_W'(1));
         check("wb1_addr", DATA_W'(app_addr), DATA_W'(28'h0ABCDE0));
         check("wb1_cmd", DATA_W'(app_cmd), DATA_W'(3'b000));
         check("wb1_wren", DATA_W'(app_wdf_wren), DATA_W'(i == 1));
         check("wb1_end", DATA_W'(app_wdf_end), DATA_W'(i == 1));
         if (i == 1) check("wb1_wdata", app_wdf_data, w1);
         tick();
      end
      check("wb1_app_en_hold", DATA_W'(app_en), DATA_W'(1));
      app_rdy = 1'b1;
      tick();
      wait_rsp("wb1", 5, cyc);
      check("wb1_latency", DATA_W'(cyc), DATA_W'(0));
      tick();
      check("wb1_pulse_once", DATA_W'(rsp_valid), DATA_W'(0));

      // Writeback: command accepted at once, data held off 3 cycles.
      $display("[TB] writeback, command before data");
      app_rdy = 1'b1; app_wdf_rdy = 1'b0;
      send_req(1'b1, 24'h123456, w2);
      sb.push_back('{rdata: d1, err: 1'b0});
      tick();
      req_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         check("wb2_app_en", DATA_W'(app_en), DATA_W'(i == 1));
         check("wb2_wren", DATA_W'(app_wdf_wren), DATA_W'(1));
         check("wb2_end", DATA_W'(app_wdf_end), DATA_W'(1));
         check("wb2_wdata", app_wdf_data, w2);
         check("wb2_no_rsp", DATA_W'(rsp_valid), DATA_W'(0));
         tick();
      end
      app_wdf_rdy = 1'b1;
      tick();
      wait_rsp("wb2", 5, cyc);
      check("wb2_latency", DATA_W'(cyc), DATA_W'(0));
      tick();
      check("wb2_pulse_once", DATA_W'(rsp_valid), DATA_W'(0));

      // Back-to-back write then read with req_valid held throughout.
      $display("[TB] back-to-back");
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      send_req(1'b1, 24'h000100, w3);
      sb.push_back('{rdata: d1, err: 1'b0});
      sb.push_back('{rdata: d2, err: 1'b0});
      tick();
      check("b2b_wr_issue", DATA_W'(app_en), DATA_W'(1));
      check("b2b_busy", DATA_W'(req_ready), DATA_W'(0));
      send_req(1'b0, 24'h000200, '0);
      tick();
      check("b2b_resp_no_en", DATA_W'(app_en), DATA_W'(0));
      check("b2b_resp_busy", DATA_W'(req_ready), DATA_W'(0));
      wait_rsp("b2b_wr", 2, cyc);
      tick();
      check("b2b_idle_no_en", DATA_W'(app_en), DATA_W'(0));
      check("b2b_idle_ready", DATA_W'(req_ready), DATA_W'(1));
      tick();
      req_valid = 1'b0;
      check("b2b_rd_en", DATA_W'(app_en), DATA_W'(1));
      check("b2b_rd_addr", DATA_W'(app_addr), DATA_W'(28'h0002000));
      check("b2b_rd_cmd", DATA_W'(app_cmd), DATA_W'(3'b001));
      tick();
      tick();
      app_rd_data = d2; app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0; app_rd_data = '0;
      wait_rsp("b2b_rd", 5, cyc);
      tick();

      // Read that never returns data: watchdog must fire.
      $display("[TB] timeout");
      send_req(1'b0, 24'h000300, '0);
      sb.push_back('{rdata: d2, err: 1'b1});
      tick();
      req_valid = 1'b0;
      wait_rsp("to", 40, cyc);
      check("to_latency", DATA_W'(cyc), DATA_W'(TO_CYC + 1));
      check("to_strobes", DATA_W'({app_en, app_wdf_wren}), DATA_W'(0));
      tick();
      app_rd_data = w1; app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0; app_rd_data = '0;
      check("to_late_data_ignored", DATA_W'(rsp_valid), DATA_W'(0));
      check("to_rdata_kept", rsp_rdata, d2);
      check("to_err_sticky", DATA_W'(rsp_err), DATA_W'(1));
      send_req(1'b1, 24'h000400, w1);
      sb.push_back('{rdata: d2, err: 1'b1});
      tick();
      req_valid = 1'b0;
      wait_rsp("after_to", 5, cyc);
      check("after_to_latency", DATA_W'(cyc), DATA_W'(1));
      tick();

      // Reset while the command is being offered.
      $display("[TB] reset mid-issue");
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      send_req(1'b1, 24'h000500, w2);
      tick();
      req_valid = 1'b0;
      check("rst_pre_en", DATA_W'(app_en), DATA_W'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_app_en", DATA_W'(app_en), DATA_W'(0));
      check("rst_wren", DATA_W'(app_wdf_wren), DATA_W'(0));
      check("rst_req_ready", DATA_W'(req_ready), DATA_W'(1));
      check("rst_rsp_err", DATA_W'(rsp_err), DATA_W'(0));
      check("rst_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
      tick();
      check("sb_drained", DATA_W'(sb.size()), DATA_W'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mig_line_initiator.md
Name: mig_line_initiator

Overview:
- Memory-side initiator for the cache-miss path.
- Converts single 128-bit cache-line fill and writeback requests from the I/D cache miss handlers into Xilinx MIG user-interface (UI) commands.
- It is the requesting end of the MIG UI protocol; dummy_mig is the simulation responder on the other side.
- One transaction outstanding at a time; runs on the MIG UI clock.

Parameters:
- ADR_W, 28, MIG app_addr width (byte address; bits [3:0] always 0).
- DATA_W, 128, cache line / MIG UI data width.
- TO_CYC, 1023, max cycles waiting on the MIG before the timeout error; counter width is clog2(TO_CYC+1).

Ports:
- clk  in  1  MIG UI clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  cache line request.
- req_wr  in  1  1 = writeback, 0 = fill.
- req_adr  in  ADR_W-4  line address (byte address [ADR_W-1:4]).
- req_wdata  in  DATA_W  writeback line data.
- req_ready  out  1  request accepted when req_valid & req_ready.
- rsp_valid  out  1  one-cycle completion pulse (fill data valid or write done).
- rsp_rdata  out  DATA_W  fill data, valid with rsp_valid on reads.
- rsp_err  out  1  sticky timeout flag; cleared only by rst.
- app_addr  out  ADR_W  {line address, 4'h0}.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_en  out  1  command valid.
- app_rdy  in  1  MIG command accept.
- app_wdf_data  out  DATA_W  write data.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equals app_wdf_wren (single-beat lines).
- app_wdf_mask  out  DATA_W/8  always 0.
- app_wdf_rdy  in  1  MIG write-data accept.
- app_rd_data  in  DATA_W  read data.
- app_rd_data_valid  in  1  read data strobe.
- app_rd_data_end  in  1  ignored (single beat).

Behaviour:
- Reset values:
  - All outputs 0 except req_ready = 1 (IDLE).
  - State = IDLE; cmd_done and wdf_done flags = 0; timeout counter = 0; rsp_err = 0.
- States: IDLE, ISSUE, RWAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid:
    - Register adr, wr, and wdata.
    - Go to ISSUE next cycle.
    - Clear cmd_done, wdf_done, and the counter.
- ISSUE:
  - app_en = !cmd_done; app_cmd = wr ? 000 : 001.
  - app_wdf_wren = app_wdf_end = wr & !wdf_done.
  - Command and data are offered concurrently; each is independent.
  - Each handshake completes in the cycle its signal and its ready are both 1, and sets its done flag. app_en/app_wdf_wren drop the following cycle.
  - For reads, wdf_done is treated as 1.
  - When both are done (counting handshakes completing this cycle):
    - Read goes to RWAIT.
    - Write goes to RESP.
  - Outputs must stay stable while waiting for ready (MIG rule).
- RWAIT:
  - Wait for app_rd_data_valid, then capture app_rd_data into rsp_rdata and go to RESP.
  - Read data arriving in the same cycle the command is accepted is impossible per MIG; no bypass is required.
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_rdata holds its value until the next fill capture.
  - Next state is IDLE; req_ready returns to 1 the cycle after RESP.
- Latency:
  - Request accept to first app_en: 1 cycle.
  - Minimum write: accept → RESP in 2 cycles.
  - Read: 1 cycle after app_rd_data_valid.
- Timeout:
  - The counter increments every cycle in ISSUE or RWAIT and resets on entering ISSUE.
  - When it reaches TO_CYC:
    - Set rsp_err.
    - Drop app_en and app_wdf_wren.
    - Go to RESP; rsp_valid pulses with rsp_rdata unchanged.
  - A later app_rd_data_valid while in IDLE is ignored.
- Mid-operation rst:
  - Returns to IDLE immediately with all MIG strobes low next cycle.
  - Clears rsp_err.
  - No recovery of in-flight MIG state is attempted.
- req_valid while not IDLE is ignored; the requester must hold it until req_ready.
- Alignment: app_addr[3:0] is hard-wired to 0.

Decomposition:
- Shared package mig_if_pkg:
  - Constants: MIG_CMD_WR = 3'b000, MIG_CMD_RD = 3'b001, LINE_OFS_W = 4.
  - State encoding typedef (IDLE, ISSUE, RWAIT, RESP).
- One natural sub-module: mig_timeout_cnt.
  - Inputs: clear, enable. Output: expired.
  - Parameterised by TO_CYC.

Test Plan:
- Fill, ideal MIG:
  - Stimulus: req adr 0x000_0040, rd; app_rdy = 1; app_rd_data_valid 5 cycles after accept with data 0x0123...CDEF.
  - Required: app_addr = 0x0000400, cmd 001; rsp_valid one pulse 1 cycle later with that data; rsp_err = 0.
- Writeback, data before command:
  - Stimulus: app_wdf_rdy = 1, app_rdy held 0 for 4 cycles.
  - Required: wdf handshake in cycle 1; app_en stays high with stable addr/cmd 000 until accepted; rsp_valid after app_rdy.
- Writeback, command before data:
  - Stimulus: app_rdy = 1, app_wdf_rdy = 0 for 3 cycles.
  - Required: app_en exactly one cycle; app_wdf_wren/end held with stable data until accepted; single rsp_valid.
- Back-to-back:
  - Stimulus: write then read with req_valid held continuously.
  - Required: second accept occurs only after RESP; no overlap of app_en.
- Timeout:
  - Stimulus: TO_CYC = 15; read with app_rd_data_valid never asserted.
  - Required: rsp_err = 1 and rsp_valid pulse after 15 RWAIT cycles; next request still completes normally; rsp_err stays 1 until rst.
- Reset mid-ISSUE:
  - Stimulus: assert rst with app_en high.
  - Required: next cycle all strobes 0, req_ready = 1, rsp_err = 0.
